// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback port arbiter.
package wb_pkg;

    localparam int unsigned DATA_W     = 36;
    localparam int unsigned VDATA_W    = 128;
    localparam int unsigned LANES      = 4;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned NUM_REQ    = 2;

    typedef enum logic [0:0] {
        REQ_SP = 1'b0,
        REQ_VP = 1'b1
    } req_e;

    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  waddr;
        logic [DATA_W-1:0]  wdata;
        logic               vwe;
        logic [ADDR_W-1:0]  vwaddr;
        logic [VDATA_W-1:0] vwdata;
        logic [LANES-1:0]   vmask;
    } wb_pkt_t;

    // Two packets collide when they both need the same register-file write port.
    function automatic logic pkts_collide(input wb_pkt_t a, input wb_pkt_t b);
        return (a.we && b.we) || (a.vwe && b.vwe);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of writeback packets; DEPTH must be a power of two >= 2.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_pkt_t          push_pkt,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output wb_pkt_t          head
);

    wb_pkt_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    // Pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: buffers scalar/vector pipeline packets and grants the
// scalar and vector register-file write ports round-robin, whole packets only.
// Optional WB_ARB_BYPASS_EN lets a packet arriving at an empty FIFO arbitrate
// in its arrival cycle.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sp_valid,
    output logic               sp_ready,
    input  logic               sp_we,
    input  logic [ADDR_W-1:0]  sp_waddr,
    input  logic [DATA_W-1:0]  sp_wdata,
    input  logic               sp_vwe,
    input  logic [ADDR_W-1:0]  sp_vwaddr,
    input  logic [VDATA_W-1:0] sp_vwdata,
    input  logic [LANES-1:0]   sp_vmask,
    input  logic               vp_valid,
    output logic               vp_ready,
    input  logic               vp_we,
    input  logic [ADDR_W-1:0]  vp_waddr,
    input  logic [DATA_W-1:0]  vp_wdata,
    input  logic               vp_vwe,
    input  logic [ADDR_W-1:0]  vp_vwaddr,
    input  logic [VDATA_W-1:0] vp_vwdata,
    input  logic [LANES-1:0]   vp_vmask,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               vrf_we,
    output logic [ADDR_W-1:0]  vrf_waddr,
    output logic [VDATA_W-1:0] vrf_wdata,
    output logic [LANES-1:0]   vrf_wmask,
    output logic               conflict
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_pkt_t            in_pkt [NUM_REQ];
    wb_pkt_t            head   [NUM_REQ];
    wb_pkt_t            cand   [NUM_REQ];
    logic [CNT_W-1:0]   count  [NUM_REQ];
    logic [NUM_REQ-1:0] in_valid;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] bypass;
    logic [NUM_REQ-1:0] cand_valid;
    logic [NUM_REQ-1:0] issue;
    req_e               rr_q;
    req_e               rr_d;
    logic               fav;
    logic               oth;
    logic               blocked;
    logic               s_fire;
    logic               v_fire;
    wb_pkt_t            s_pkt;
    wb_pkt_t            v_pkt;

    assign in_valid = {vp_valid, sp_valid};
    assign sp_ready = ready[REQ_SP];
    assign vp_ready = ready[REQ_VP];

    assign in_pkt[REQ_SP] = '{we: sp_we, waddr: sp_waddr, wdata: sp_wdata,
                              vwe: sp_vwe, vwaddr: sp_vwaddr, vwdata: sp_vwdata,
                              vmask: sp_vmask};
    assign in_pkt[REQ_VP] = '{we: vp_we, waddr: vp_waddr, wdata: vp_wdata,
                              vwe: vp_vwe, vwaddr: vp_vwaddr, vwdata: vp_vwdata,
                              vmask: vp_vmask};

    wb_fifo #(.DEPTH(DEPTH)) u_sp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[REQ_SP]),
        .push_pkt (in_pkt[REQ_SP]),
        .pop      (pop[REQ_SP]),
        .count    (count[REQ_SP]),
        .head     (head[REQ_SP])
    );

    wb_fifo #(.DEPTH(DEPTH)) u_vp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[REQ_VP]),
        .push_pkt (in_pkt[REQ_VP]),
        .pop      (pop[REQ_VP]),
        .count    (count[REQ_VP]),
        .head     (head[REQ_VP])
    );

    // Arbitration candidates: FIFO heads, or the live input when bypassing an empty FIFO.
    always_comb begin
        bypass     = '0;
        cand_valid = '0;
        ready      = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            ready[r] = count[r] < CNT_W'(DEPTH);
`ifdef WB_ARB_BYPASS_EN
            bypass[r] = in_valid[r] && (count[r] == '0);
`endif
            cand_valid[r] = (count[r] != '0) || bypass[r];
            cand[r]       = bypass[r] ? in_pkt[r] : head[r];
        end
    end

    // Round-robin grant, rr next state, FIFO push/pop and write-port selection.
    always_comb begin
        fav        = rr_q;
        oth        = ~fav;
        issue      = '0;
        push       = '0;
        pop        = '0;
        issue[fav] = cand_valid[fav];
        issue[oth] = cand_valid[oth] &&
                     (!cand_valid[fav] || !pkts_collide(cand[fav], cand[oth]));
        blocked    = (&cand_valid) && !(&issue);
        rr_d       = blocked ? req_e'(oth) : rr_q;
        for (int r = 0; r < NUM_REQ; r++) begin
            pop[r]  = issue[r] && !bypass[r];
            push[r] = in_valid[r] && ready[r] && !(bypass[r] && issue[r]);
        end
        s_fire = (issue[REQ_SP] && cand[REQ_SP].we)  || (issue[REQ_VP] && cand[REQ_VP].we);
        v_fire = (issue[REQ_SP] && cand[REQ_SP].vwe) || (issue[REQ_VP] && cand[REQ_VP].vwe);
        s_pkt  = (issue[REQ_SP] && cand[REQ_SP].we)  ? cand[REQ_SP] : cand[REQ_VP];
        v_pkt  = (issue[REQ_SP] && cand[REQ_SP].vwe) ? cand[REQ_SP] : cand[REQ_VP];
    end

    // Round-robin pointer; scalar pipeline favoured out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) rr_q <= REQ_SP;
        else        rr_q <= rr_d;
    end

    // Write-port registers; address/data hold when their port is not written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            vrf_we    <= 1'b0;
            vrf_waddr <= '0;
            vrf_wdata <= '0;
            vrf_wmask <= '0;
            conflict  <= 1'b0;
        end else begin
            rf_we    <= s_fire;
            vrf_we   <= v_fire;
            conflict <= blocked;
            if (s_fire) begin
                rf_waddr <= s_pkt.waddr;
                rf_wdata <= s_pkt.wdata;
            end
            if (v_fire) begin
                vrf_waddr <= v_pkt.vwaddr;
                vrf_wdata <= v_pkt.vwdata;
                vrf_wmask <= v_pkt.vmask;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-level reference model predicts
// every register-file write; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
    import wb_pkg::*;

`ifdef WB_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int                 cyc;
        logic [ADDR_W-1:0]  addr;
        logic [VDATA_W-1:0] data;
        logic [LANES-1:0]   mask;
    } exp_wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               drv_rst_n;
    bit                 drv_v [2];
    wb_pkt_t            drv_p [2];
    logic               sp_ready, vp_ready;
    logic               rf_we, vrf_we, conflict;
    logic [ADDR_W-1:0]  rf_waddr, vrf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [VDATA_W-1:0] vrf_wdata;
    logic [LANES-1:0]   vrf_wmask;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model state
    wb_pkt_t mq  [2][$];
    wb_pkt_t src [2][$];
    exp_wr_t exp_s[$];
    exp_wr_t exp_v[$];
    int      m_rr = 0;
    bit      m_conflict = 0;
    bit      m_ready [2] = '{1, 1};
    bit      m_acc   [2] = '{0, 0};

    wb_port_arbiter dut (
        .clk       (clk),
        .rst_n     (drv_rst_n),
        .sp_valid  (drv_v[0]),
        .sp_ready  (sp_ready),
        .sp_we     (drv_p[0].we),
        .sp_waddr  (drv_p[0].waddr),
        .sp_wdata  (drv_p[0].wdata),
        .sp_vwe    (drv_p[0].vwe),
        .sp_vwaddr (drv_p[0].vwaddr),
        .sp_vwdata (drv_p[0].vwdata),
        .sp_vmask  (drv_p[0].vmask),
        .vp_valid  (drv_v[1]),
        .vp_ready  (vp_ready),
        .vp_we     (drv_p[1].we),
        .vp_waddr  (drv_p[1].waddr),
        .vp_wdata  (drv_p[1].wdata),
        .vp_vwe    (drv_p[1].vwe),
        .vp_vwaddr (drv_p[1].vwaddr),
        .vp_vwdata (drv_p[1].vwdata),
        .vp_vmask  (drv_p[1].vmask),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .vrf_wmask (vrf_wmask),
        .conflict  (conflict)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    function automatic wb_pkt_t mk(bit we, int wa, logic [DATA_W-1:0] wd,
                                   bit vwe, int va, logic [VDATA_W-1:0] vd,
                                   logic [LANES-1:0] vm);
        wb_pkt_t p;
        p.we = we; p.waddr = ADDR_W'(wa); p.wdata = wd;
        p.vwe = vwe; p.vwaddr = ADDR_W'(va); p.vwdata = vd; p.vmask = vm;
        return p;
    endfunction

    function automatic wb_pkt_t rand_pkt();
        logic [VDATA_W-1:0] vd;
        vd = {$urandom, $urandom, $urandom, $urandom};
        return mk(1'($urandom_range(1)), int'($urandom_range(31)),
                  DATA_W'({$urandom, $urandom}), 1'($urandom_range(1)),
                  int'($urandom_range(31)), vd, LANES'($urandom));
    endfunction

    // Predicts what happens at the coming edge from the FIFO contents and the driven inputs.
    function automatic void model_step();
        bit      has [2];
        bit      byp [2];
        bit      iss [2];
        wb_pkt_t c   [2];
        int      f, o;
        bit      clash;
        if (!drv_rst_n) begin
            mq[0].delete(); mq[1].delete();
            m_rr = 0; m_conflict = 0;
            m_acc = '{0, 0}; m_ready = '{1, 1};
            return;
        end
        for (int r = 0; r < 2; r++) begin
            byp[r] = 0;
            c[r]   = '0;
            has[r] = mq[r].size() > 0;
            if (has[r]) c[r] = mq[r][0];
`ifdef WB_ARB_BYPASS_EN
            if (!has[r] && drv_v[r]) begin
                byp[r] = 1; has[r] = 1; c[r] = drv_p[r];
            end
`endif
        end
        f = m_rr;
        o = 1 - m_rr;
        clash  = (c[0].we && c[1].we) || (c[0].vwe && c[1].vwe);
        iss[f] = has[f];
        iss[o] = has[o] && (!has[f] || !clash);
        m_conflict = has[0] && has[1] && !(iss[0] && iss[1]);
        if (m_conflict) m_rr = o;
        for (int r = 0; r < 2; r++) m_acc[r] = drv_v[r] && (mq[r].size() < FIFO_DEPTH);
        for (int r = 0; r < 2; r++) begin
            if (iss[r]) begin
                if (c[r].we)  exp_s.push_back('{edge_n + 1, c[r].waddr, VDATA_W'(c[r].wdata), '0});
                if (c[r].vwe) exp_v.push_back('{edge_n + 1, c[r].vwaddr, c[r].vwdata, c[r].vmask});
                if (!byp[r]) void'(mq[r].pop_front());
            end
        end
        for (int r = 0; r < 2; r++)
            if (m_acc[r] && !(byp[r] && iss[r])) mq[r].push_back(drv_p[r]);
        for (int r = 0; r < 2; r++) m_ready[r] = mq[r].size() < FIFO_DEPTH;
    endfunction

    // Monitor: every DUT write must match the oldest predicted write, on the predicted edge.
    always @(negedge clk) begin
        exp_wr_t e;
        if (rf_we === 1'b1) begin
            if (exp_s.size() == 0) check("rf_we_unexpected", 128'(rf_we), 128'(0));
            else begin
                e = exp_s.pop_front();
                check("rf_edge",  128'(edge_n),   128'(e.cyc));
                check("rf_waddr", 128'(rf_waddr), 128'(e.addr));
                check("rf_wdata", 128'(rf_wdata), e.data);
            end
        end else if (exp_s.size() > 0 && exp_s[0].cyc <= edge_n) begin
            void'(exp_s.pop_front());
            check("rf_we_missing", 128'(rf_we), 128'(1));
        end
        if (vrf_we === 1'b1) begin
            if (exp_v.size() == 0) check("vrf_we_unexpected", 128'(vrf_we), 128'(0));
            else begin
                e = exp_v.pop_front();
                check("vrf_edge",  128'(edge_n),    128'(e.cyc));
                check("vrf_waddr", 128'(vrf_waddr), 128'(e.addr));
                check("vrf_wdata", vrf_wdata,       e.data);
                check("vrf_wmask", 128'(vrf_wmask), 128'(e.mask));
            end
        end else if (exp_v.size() > 0 && exp_v[0].cyc <= edge_n) begin
            void'(exp_v.pop_front());
            check("vrf_we_missing", 128'(vrf_we), 128'(1));
        end
        check("conflict", 128'(conflict), 128'(m_conflict));
        check("sp_ready", 128'(sp_ready), 128'(m_ready[0]));
        check("vp_ready", 128'(vp_ready), 128'(m_ready[1]));
    end

    task automatic step();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        drv_v = '{0, 0};
        repeat (n) step();
    endtask

    // Feeds source queues with valid/ready handshakes; gap is the percent chance of an idle slot.
    task automatic run_src(int n, int gap, output int vcnt, output int first_v,
                           output int last_v, output int rdy_low);
        vcnt = 0; first_v = -1; last_v = -1; rdy_low = 0;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 2; r++) begin
                drv_v[r] = (src[r].size() > 0) && (int'($urandom_range(99)) >= gap);
                if (src[r].size() > 0) drv_p[r] = src[r][0];
            end
            model_step();
            for (int r = 0; r < 2; r++) if (m_acc[r]) void'(src[r].pop_front());
            @(negedge clk);
            #1;
            if (vrf_we === 1'b1) begin
                vcnt++;
                if (first_v < 0) first_v = edge_n;
                last_v = edge_n;
            end
            if (sp_ready === 1'b0 || vp_ready === 1'b0) rdy_low++;
        end
        drv_v = '{0, 0};
    endtask

    // Single scalar packet from sp; rf_we must appear exactly LAT edges after it is presented.
    task automatic latency_probe(int addr, logic [DATA_W-1:0] data);
        drv_v[0] = 1;
        drv_p[0] = mk(1, addr, data, 0, 0, '0, '0);
        for (int e = 1; e <= 3; e++) begin
            step();
            drv_v[0] = 0;
            check("probe_rf_we", 128'(rf_we), 128'(e == LAT));
            if (e == LAT) begin
                check("probe_waddr", 128'(rf_waddr), 128'(addr));
                check("probe_wdata", 128'(rf_wdata), 128'(data));
            end
            check("probe_vrf_we", 128'(vrf_we), 128'(0));
        end
    endtask

    initial begin
        int vcnt, first_v, last_v, rdy_low, ccnt, both, budget;
        drv_rst_n = 0;
        drv_v = '{0, 0};
        drv_p = '{'0, '0};
        repeat (2) step();
        check("rst_rf_we",     128'(rf_we),     128'(0));
        check("rst_rf_waddr",  128'(rf_waddr),  128'(0));
        check("rst_rf_wdata",  128'(rf_wdata),  128'(0));
        check("rst_vrf_we",    128'(vrf_we),    128'(0));
        check("rst_vrf_wdata", vrf_wdata,       128'(0));
        check("rst_vrf_wmask", 128'(vrf_wmask), 128'(0));
        check("rst_sp_ready",  128'(sp_ready),  128'(1));
        drv_rst_n = 1;
        idle(1);

        // Scalar-only writes and latency
        latency_probe(3, 36'h1_2345_6789);
        latency_probe(7, DATA_W'({$urandom, $urandom}));

        // Collision on the scalar port: sp first, vp next cycle, one conflict pulse
        drv_v = '{1, 1};
        drv_p[0] = mk(1, 1, 36'h0_0000_1111, 0, 0, '0, '0);
        drv_p[1] = mk(1, 2, 36'h0_0000_2222, 0, 0, '0, '0);
        ccnt = 0;
        step();
        drv_v = '{0, 0};
        ccnt += int'(conflict);
        for (int i = 0; i < 4; i++) begin step(); ccnt += int'(conflict); end
        check("collision_conflict_pulses", 128'(ccnt), 128'(1));
        check("collision_rr_vp", 128'(dut.rr_q), 128'(1));

        // Disjoint ports: both writes land together, no conflict
        drv_v = '{1, 1};
        drv_p[0] = mk(1, 4, 36'h0_0000_4444, 0, 0, '0, '0);
        drv_p[1] = mk(0, 0, '0, 1, 2, {4{32'hCAFE_0002}}, 4'b1010);
        ccnt = 0; both = 0;
        step();
        drv_v = '{0, 0};
        for (int i = 0; i < 4; i++) begin
            if (rf_we === 1'b1 && vrf_we === 1'b1) both++;
            ccnt += int'(conflict);
            step();
        end
        check("disjoint_same_cycle", 128'(both), 128'(1));
        check("disjoint_conflict", 128'(ccnt), 128'(0));

        // Backpressure: 4 vector packets each side, 8 back-to-back vrf writes
        for (int i = 0; i < 4; i++) begin
            src[0].push_back(mk(0, 0, '0, 1, i, {4{32'(i)}}, 4'hF));
            src[1].push_back(mk(0, 0, '0, 1, 16 + i, {4{32'(16 + i)}}, 4'h5));
        end
        run_src(14, 0, vcnt, first_v, last_v, rdy_low);
        check("bp_vrf_writes", 128'(vcnt), 128'(8));
        check("bp_consecutive", 128'(last_v - first_v), 128'(7));
        check("bp_ready_dropped", 128'(rdy_low > 0), 128'(1));
        check("bp_src_drained", 128'(src[0].size() + src[1].size()), 128'(0));

        // Reset mid-stream with both FIFOs filling
        for (int i = 0; i < 8; i++) begin
            src[0].push_back(mk(0, 0, '0, 1, 8 + i, {4{$urandom}}, 4'h3));
            src[1].push_back(mk(0, 0, '0, 1, 24 + i, {4{$urandom}}, 4'hC));
        end
        run_src(4, 0, vcnt, first_v, last_v, rdy_low);
        drv_v = '{1, 1};
        drv_rst_n = 0;
        step();
        src[0].delete(); src[1].delete();
        drv_rst_n = 1;
        drv_v = '{0, 0};
        check("midrst_rf_we",    128'(rf_we),    128'(0));
        check("midrst_vrf_we",   128'(vrf_we),   128'(0));
        check("midrst_sp_ready", 128'(sp_ready), 128'(1));
        check("midrst_vp_ready", 128'(vp_ready), 128'(1));
        idle(6);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            src[0].push_back(rand_pkt());
            src[1].push_back(rand_pkt());
        end
        budget = 0;
        while ((src[0].size() + src[1].size() + mq[0].size() + mq[1].size()) > 0 && budget < 2000) begin
            run_src(1, 30, vcnt, first_v, last_v, rdy_low);
            budget++;
        end
        check("random_drain_in_budget", 128'(budget < 2000), 128'(1));
        idle(4);
        check("exp_s_empty", 128'(exp_s.size()), 128'(0));
        check("exp_v_empty", 128'(exp_v.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
